ts_bus_reader: RTL and testbench
================================

Name: ts_bus_reader

Overview:
- Synchronous initiator for the shared single-bit tri-state bus (8-bit address out, 1-bit data back).
- It receives a read request for a base address and a bit count. It then drives consecutive addresses onto the bus and waits a settle time at each one. It samples the returned data bit and packs the bits into a word.
- It replaces the untimed address stimulus on the master side of the bus. Address-decoding slaves that drive Data on a match sit on the other end.

Parameters:
- MAX_BITS, 8, width of rd_data and the maximum number of bits per transaction (1..16).
- SETTLE_CYC, 2, clock cycles each address is held before its data bit is sampled (>=1).
- IDLE_ADRS, 8'hFF, address driven when no transaction is active. No slave decodes it.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req  input  1  start request, sampled only in IDLE
- req_adrs  input  8  first bus address of the transaction
- req_len  input  $clog2(MAX_BITS+1)  number of bits to read; 0 or values >MAX_BITS are treated as MAX_BITS
- busy  output  1  transaction in progress
- bus_adrs  output  8  address onto the shared bus (master-side Adrs)
- bus_data  input  1  shared tri-state data line as seen by the master
- rd_valid  output  1  one-cycle pulse: rd_data is complete
- rd_data  output  MAX_BITS  assembled word; the bit from the first address is in bit 0

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- Reset state, applied at any clk edge with rst_n=0 including mid-transaction:
  - FSM=IDLE, busy=0, bus_adrs=IDLE_ADRS, rd_valid=0, rd_data=0, counters=0.
  - A transaction in flight is dropped; no rd_valid is produced for it.
- FSM states: IDLE, SETTLE.
- IDLE:
  - On an edge with req=1, accept the request:
    - cur_adrs<=req_adrs, bus_adrs<=req_adrs
    - len<=effective length, bit_idx<=0, cnt<=0
    - rd_data<=0, busy<=1, go to SETTLE.
  - Otherwise bus_adrs holds IDLE_ADRS.
- SETTLE: bus_adrs=cur_adrs; cnt increments each edge.
  - On the edge where cnt==SETTLE_CYC-1:
    - rd_data[bit_idx]<=bus_data, cnt<=0.
    - If bit_idx==len-1: bus_adrs<=IDLE_ADRS, busy<=0, rd_valid<=1, go to IDLE.
    - Else: bit_idx++, cur_adrs<=cur_adrs+1 (8-bit wrap, 8'hFF->8'h00), bus_adrs follows.
- Latency: rd_valid is high in the cycle following the edge that is N*SETTLE_CYC edges after the accept edge (N = effective length).
- Address and data handshake:
  - Each address is driven for exactly SETTLE_CYC cycles.
  - The bus_data sample is taken at the last edge of that window.
- rd_valid:
  - Exactly one cycle wide.
  - busy falls on the same edge that rd_valid rises.
- Back-to-back requests:
  - req is ignored while busy=1; there is no queue.
  - req=1 in the rd_valid cycle is accepted (FSM is already IDLE), which clears rd_data on that edge.
- rd_data stability:
  - Bits fill in progressively during a transaction.
  - The word is stable from rd_valid until the next accepted request.
  - Bits at index >=len stay 0.
- Undriven bus: bus_data is stored as received. Integration places a pull-down on Data, so an undecoded address reads 0; no Z detection is done in this block.
- No arithmetic other than the address increment (modulo 256) and the counters; cnt width is $clog2(SETTLE_CYC+1).

Test Plan:
- Bench model: slaves at 50 (data=d50) and 42 (data=d42), Data pull-down.
  - Stimulus: req_adrs=42, req_len=1, d42=1.
  - Required response: bus_adrs=42 for 2 cycles, rd_valid after 2 edges, rd_data=8'h01, bus_adrs returns to 8'hFF.
- Word read with a gap in decoding.
  - Model: slaves at 42..49 with d=8'hA5 pattern; slave 45 removed (pull-down).
  - Stimulus: req_adrs=42, req_len=8.
  - Required response: rd_data=8'hA5 & ~8'h08 = 8'hA5 (bit3 of A5 is 0); rd_valid at accept+16.
  - Repeat with d=8'h5A: required rd_data=8'h52.
- Wrap-around.
  - Stimulus: req_adrs=8'hFE, req_len=3.
  - Required response: bus_adrs sequence FE,FE,FF,FF,00,00 then IDLE_ADRS; rd_valid once.
- Length boundary.
  - Stimulus: req_len=0, then req_len=15 (MAX_BITS=8).
  - Required response: both read 8 bits, 16-cycle latency each.
  - Stimulus: req_len=3.
  - Required response: rd_data[7:3]=0.
- Request handling.
  - Stimulus: req held high continuously.
  - Required response: transactions back-to-back; req pulses during busy are ignored; new accept in the rd_valid cycle restarts with bus_adrs=req_adrs on that edge.
- Reset mid-transaction.
  - Stimulus: rst_n=0 for 1 cycle at bit 4 of an 8-bit read.
  - Required response: next edge busy=0, bus_adrs=8'hFF, rd_data=0, no rd_valid; a following request completes normally.

Source files
------------

// File: rtl/ts_bus_reader.sv
// -----------------------------------------------------------------------------
// ts_bus_reader
//
// Master-side initiator for the shared single-bit tri-state bus. A read request
// names a base address and a bit count. The block walks consecutive addresses
// (8-bit wrap) on bus_adrs and holds each address for SETTLE_CYC cycles. It
// samples bus_data on the last edge of each window and packs the samples LSB
// first into rd_data. rd_valid pulses for one cycle when the word is complete.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   req        in   start request, only looked at while idle
//   req_adrs   in   [7:0]  first bus address of the transaction
//   req_len    in   [LEN_W-1:0] bit count; 0 or > MAX_BITS means MAX_BITS
//   busy       out  transaction in progress
//   bus_adrs   out  [7:0]  address driven onto the shared bus
//   bus_data   in   data line as seen by the master (pulled down when undriven)
//   rd_valid   out  one-cycle pulse, rd_data complete
//   rd_data    out  [MAX_BITS-1:0] assembled word, first address in bit 0
//   dbg_state  out  current FSM state (0 = IDLE, 1 = SETTLE)
//
// Handshake: req is a level that is sampled only on edges where the FSM is
// IDLE. There is no ready output. Requests that arrive while busy=1 are
// dropped. rd_valid has no back-pressure. The word in rd_data stays stable
// from rd_valid until the next accepted request.
// -----------------------------------------------------------------------------
module ts_bus_reader #(
  parameter int          MAX_BITS   = 8,
  parameter int          SETTLE_CYC = 2,
  parameter logic [7:0]  IDLE_ADRS  = 8'hFF,
  localparam int         LEN_W      = $clog2(MAX_BITS + 1),
  localparam int         CNT_W      = $clog2(SETTLE_CYC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic [7:0]          req_adrs,
  input  logic [LEN_W-1:0]    req_len,
  output logic                busy,
  output logic [7:0]          bus_adrs,
  input  logic                bus_data,
  output logic                rd_valid,
  output logic [MAX_BITS-1:0] rd_data,
  output logic                dbg_state
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  // Registered state
  state_t                r_state;
  logic [7:0]            r_cur_adrs;
  logic [7:0]            r_bus_adrs;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_bit_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [MAX_BITS-1:0]   r_rd_data;
  logic                  r_busy;
  logic                  r_rd_valid;

  // Next-state values
  state_t                w_state_nxt;
  logic [7:0]            w_cur_adrs_nxt;
  logic [7:0]            w_bus_adrs_nxt;
  logic [LEN_W-1:0]      w_len_nxt;
  logic [LEN_W-1:0]      w_bit_idx_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [MAX_BITS-1:0]   w_rd_data_nxt;
  logic                  w_busy_nxt;
  logic                  w_rd_valid_nxt;

  // Helper decodes
  logic [LEN_W-1:0]      w_eff_len;
  logic                  w_last_cnt;
  logic                  w_last_bit;

  // A zero length or a length above MAX_BITS reads a full word.
  assign w_eff_len  = ((req_len == '0) || (req_len > LEN_MAX)) ? LEN_MAX : req_len;
  assign w_last_cnt = (r_cnt == CNT_LAST);
  assign w_last_bit = (r_bit_idx == (r_len - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_adrs_nxt = r_cur_adrs;
    w_bus_adrs_nxt = r_bus_adrs;
    w_len_nxt      = r_len;
    w_bit_idx_nxt  = r_bit_idx;
    w_cnt_nxt      = r_cnt;
    w_rd_data_nxt  = r_rd_data;
    w_busy_nxt     = r_busy;
    w_rd_valid_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_bus_adrs_nxt = IDLE_ADRS;
        if (req) begin
          w_cur_adrs_nxt = req_adrs;
          w_bus_adrs_nxt = req_adrs;
          w_len_nxt      = w_eff_len;
          w_bit_idx_nxt  = '0;
          w_cnt_nxt      = '0;
          w_rd_data_nxt  = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        w_bus_adrs_nxt = r_cur_adrs;
        w_cnt_nxt      = r_cnt + CNT_W'(1);
        if (w_last_cnt) begin
          // The settle window ends here. Sample the line into the current bit slot.
          w_cnt_nxt = '0;
          for (int i = 0; i < MAX_BITS; i++) begin
            if (r_bit_idx == LEN_W'(i)) begin
              w_rd_data_nxt[i] = bus_data;
            end
          end
          if (w_last_bit) begin
            w_bus_adrs_nxt = IDLE_ADRS;
            w_busy_nxt     = 1'b0;
            w_rd_valid_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            // 8-bit increment wraps FF -> 00 naturally.
            w_bit_idx_nxt  = r_bit_idx + LEN_W'(1);
            w_cur_adrs_nxt = r_cur_adrs + 8'd1;
            w_bus_adrs_nxt = r_cur_adrs + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_bus_adrs_nxt = IDLE_ADRS;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cur_adrs <= '0;
      r_bus_adrs <= IDLE_ADRS;
      r_len      <= '0;
      r_bit_idx  <= '0;
      r_cnt      <= '0;
      r_rd_data  <= '0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_adrs <= w_cur_adrs_nxt;
      r_bus_adrs <= w_bus_adrs_nxt;
      r_len      <= w_len_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_busy     <= w_busy_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  assign busy      = r_busy;
  assign bus_adrs  = r_bus_adrs;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Embedded properties
  // ---------------------------------------------------------------------------
  // rd_valid never lasts more than one cycle.
  a_valid_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    r_rd_valid |=> !r_rd_valid);

  // busy and rd_valid are never high together.
  a_valid_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_rd_valid && r_busy));

  // The idle address is on the bus whenever no transaction is running.
  a_idle_adrs: assert property (@(posedge clk) disable iff (!rst_n)
    !r_busy |-> (r_bus_adrs == IDLE_ADRS));

endmodule

// File: tb/tb_ts_bus_reader.sv
module tb_ts_bus_reader;

  localparam int MB = 8;
  localparam int S  = 2;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req = 1'b0;
  logic [7:0]  req_adrs = 8'h00;
  logic [3:0]  req_len = 4'd0;
  logic        busy;
  logic [7:0]  bus_adrs;
  logic        bus_data;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        dbg_state;

  ts_bus_reader #(.MAX_BITS(MB), .SETTLE_CYC(S), .IDLE_ADRS(8'hFF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_adrs  (req_adrs),
    .req_len   (req_len),
    .busy      (busy),
    .bus_adrs  (bus_adrs),
    .bus_data  (bus_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .dbg_state (dbg_state)
  );

  // Slave population: a slave drives its bit when its address is on the bus;
  // otherwise the pull-down gives 0.
  logic slave_en [256];
  logic slave_d  [256];
  assign bus_data = slave_en[bus_adrs] & slave_d[bus_adrs];

  function automatic logic slave_val(input logic [7:0] a);
    return slave_en[a] & slave_d[a];
  endfunction

  task automatic clear_slaves();
    for (int i = 0; i < 256; i++) begin
      slave_en[i] = 1'b0;
      slave_d[i]  = 1'b0;
    end
  endtask

  // Eight consecutive slaves starting at 'base' carrying 'pat' (bit i at base+i).
  task automatic load_pattern(input logic [7:0] base, input logic [7:0] pat);
    logic [7:0] p;
    p = pat;
    for (int i = 0; i < 8; i++) begin
      slave_en[8'(base + 8'(i))] = 1'b1;
      slave_d[8'(base + 8'(i))]  = p[i];
    end
  endtask

  // --------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];
  int         lat_q [$];
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- behaviour model
  // Timeline view: k edges after the accept edge, the bus carries base + k/S.
  // Bit i is the slave value at base+i and is captured k=(i+1)*S edges in.
  // The word is complete, and busy drops, when k = len*S.
  int         cyc = 0;
  int         m_acc = 0;
  int         m_k = 0;
  int         m_len = 0;
  logic [7:0] m_base = 8'h00;
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_word = 8'h00;

  function automatic int eff_len(input logic [3:0] l);
    if (l == 4'd0 || int'(l) > MB) return MB;
    return int'(l);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_word  = 8'h00;
      m_k     = 0;
    end else if (!m_busy) begin
      m_valid = 1'b0;
      if (req) begin
        m_base = req_adrs;
        m_len  = eff_len(req_len);
        m_k    = 0;
        m_word = 8'h00;
        m_busy = 1'b1;
        m_acc  = cyc;
      end
    end else begin
      m_k++;
      if (m_k % S == 0) m_word[m_k / S - 1] = slave_val(8'(m_base + 8'(m_k / S - 1)));
      if (m_k == m_len * S) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
      end
    end
  end

  // ------------------------------------------------------- compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",     {31'd0, busy},     {31'd0, m_busy});
      chk("bus_adrs", {24'd0, bus_adrs}, {24'd0, (m_busy ? 8'(m_base + 8'(m_k / S)) : 8'hFF)});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
      chk("rd_data",  {24'd0, rd_data},  {24'd0, m_word});
      if (rd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rd_valid actual=1 required=0 rd_data=%0h at %0t", rd_data, $time);
        end else begin
          logic [7:0] ew;
          int         el;
          ew = exp_q.pop_front();
          el = lat_q.pop_front();
          chk("word",       {24'd0, rd_data}, {24'd0, ew});
          chk("model_word", {24'd0, m_word},  {24'd0, ew});
          chk("latency",    32'(cyc - m_acc), 32'(el));
        end
      end
    end
  end

  // ------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits, with a cycle budget, for the negedge at which rd_valid is high.
  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rd_valid !== 1'b1 && n < 100);
    if (rd_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL timeout actual=no_rd_valid required=rd_valid within 100 cycles at %0t", $time);
    end
  endtask

  // Issues one request. If 'pulse' is set, a stray req for address 50 is
  // raised mid-transaction and must have no effect.
  task automatic do_req(input logic [7:0] a, input logic [3:0] l,
                        input logic [7:0] w, input int lat, input bit pulse);
    exp_q.push_back(w);
    lat_q.push_back(lat);
    req_adrs = a;
    req_len  = l;
    req      = 1'b1;
    tick();
    req = 1'b0;
    if (pulse) begin
      repeat (3) @(negedge clk);
      req_adrs = 8'd50;
      req      = 1'b1;
      @(negedge clk);
      req      = 1'b0;
      req_adrs = a;
    end
    wait_valid();
  endtask

  // ----------------------------------------------------------------- stimulus
  logic [7:0] wrap_seq [7];
  logic [7:0] wrap_exp [7] = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};

  initial begin
    clear_slaves();

    // Reset state
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("reset_busy",     {31'd0, busy},     32'd0);
    chk("reset_bus_adrs", {24'd0, bus_adrs}, 32'hFF);
    chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset_rd_data",  {24'd0, rd_data},  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single bit from slave 42; slave 50 also present.
    slave_en[42] = 1'b1; slave_d[42] = 1'b1;
    slave_en[50] = 1'b1; slave_d[50] = 1'b0;
    do_req(8'd42, 4'd1, 8'h01, 2, 1'b0);
    @(negedge clk);

    // Word read with slave 45 missing, A5 then 5A.
    clear_slaves();
    load_pattern(8'd42, 8'hA5);
    slave_en[45] = 1'b0;
    do_req(8'd42, 4'd8, 8'hA5, 16, 1'b1);
    clear_slaves();
    load_pattern(8'd42, 8'h5A);
    slave_en[45] = 1'b0;
    do_req(8'd42, 4'd8, 8'h52, 16, 1'b0);

    // Length boundaries: 0 and 15 both mean 8 bits.
    do_req(8'd42, 4'd0,  8'h52, 16, 1'b0);
    do_req(8'd42, 4'd15, 8'h52, 16, 1'b0);

    // Short read over all-ones slaves: upper bits must stay 0.
    clear_slaves();
    load_pattern(8'd42, 8'hFF);
    do_req(8'd42, 4'd3, 8'h07, 6, 1'b0);
    @(negedge clk);

    // Wrap-around FE, FF, 00
    clear_slaves();
    slave_en[8'hFE] = 1'b1; slave_d[8'hFE] = 1'b1;
    slave_en[8'h00] = 1'b1; slave_d[8'h00] = 1'b1;
    exp_q.push_back(8'h05);
    lat_q.push_back(6);
    req_adrs = 8'hFE;
    req_len  = 4'd3;
    req      = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      wrap_seq[i] = bus_adrs;
    end
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("wrap_adrs_%0d", i), {24'd0, wrap_seq[i]}, {24'd0, wrap_exp[i]});
    end
    @(negedge clk);

    // req held high: three back-to-back 2-bit reads.
    clear_slaves();
    load_pattern(8'd42, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h03);
      lat_q.push_back(4);
    end
    req_adrs = 8'd42;
    req_len  = 4'd2;
    req      = 1'b1;
    for (int i = 0; i < 3; i++) wait_valid();
    req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of an 8-bit read (around bit 4).
    clear_slaves();
    load_pattern(8'd42, 8'h5A);
    slave_en[45] = 1'b0;
    req_adrs = 8'd42;
    req_len  = 4'd8;
    req      = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_busy",     {31'd0, busy},     32'd0);
    chk("midrst_bus_adrs", {24'd0, bus_adrs}, 32'hFF);
    chk("midrst_rd_data",  {24'd0, rd_data},  32'd0);
    chk("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    repeat (20) @(negedge clk);
    do_req(8'd42, 4'd8, 8'h52, 16, 1'b0);
    repeat (3) @(negedge clk);

    // Every expected word must have been matched by a rd_valid.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_words actual=%0d required=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
